// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap initiator (exception/interrupt/mret select, CSR handshake, fetch redirect).
// Define TRAP_CTRL_VECTORED_EN to enable vectored interrupt targets when mtvec[1:0]=01.
module trap_ctrl #(
  parameter int MXLEN = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [MXLEN-1:0] i_pc,
  input  logic             i_exc_iaddr_mis,
  input  logic             i_exc_illegal,
  input  logic             i_exc_ebreak,
  input  logic             i_exc_ecall,
  input  logic             i_exc_laddr_mis,
  input  logic             i_exc_saddr_mis,
  input  logic [MXLEN-1:0] i_exc_tval,
  input  logic             i_mret,
  input  logic             i_irq_soft,
  input  logic             i_irq_timer,
  input  logic             i_irq_ext,
  input  logic             i_mstatus_mie,
  input  logic [MXLEN-1:0] i_mie,
  input  logic [MXLEN-1:0] i_mtvec,
  input  logic [MXLEN-1:0] i_mepc,
  output logic             o_flush,
  output logic             o_stall,
  output logic             o_trap_req,
  output logic [MXLEN-1:0] o_trap_cause,
  output logic [MXLEN-1:0] o_trap_tval,
  output logic [MXLEN-1:0] o_trap_pc,
  output logic             o_mret_req,
  output logic             o_redirect,
  output logic [MXLEN-1:0] o_redirect_pc,
  output logic [MXLEN-1:0] o_mip
);
  typedef enum logic [1:0] {IDLE, TRAP, MRET, REDIR} state_t;
  state_t           r_state;
  logic [2:0]       r_mip;
  logic [MXLEN-1:0] r_target;
  logic [MXLEN-1:0] w_en, w_base, w_target, w_tval;
  logic [MXLEN-2:0] w_code;
  logic             w_irq, w_exc, w_sel, w_vec, w_unused;

  always_comb begin
    o_mip     = '0;
    o_mip[3]  = r_mip[0];
    o_mip[7]  = r_mip[1];
    o_mip[11] = r_mip[2];
  end

  assign w_en  = o_mip & i_mie & {MXLEN{i_mstatus_mie}};
  assign w_irq = w_en[11] | w_en[3] | w_en[7];
  assign w_exc = i_exc_iaddr_mis | i_exc_illegal | i_exc_ebreak | i_exc_ecall |
                 i_exc_laddr_mis | i_exc_saddr_mis;
  assign w_sel = (r_state == IDLE) && i_valid && (w_irq || w_exc || i_mret);
  // Gated by reset so nothing leaks out of the block while it is held in reset.
  assign o_flush = i_rst && w_sel;
  assign o_stall = r_state != IDLE;

  assign w_code = w_en[11]        ? (MXLEN-1)'(11) :
                  w_en[3]         ? (MXLEN-1)'(3)  :
                  w_en[7]         ? (MXLEN-1)'(7)  :
                  i_exc_iaddr_mis ? (MXLEN-1)'(0)  :
                  i_exc_illegal   ? (MXLEN-1)'(2)  :
                  i_exc_ebreak    ? (MXLEN-1)'(3)  :
                  i_exc_ecall     ? (MXLEN-1)'(11) :
                  i_exc_laddr_mis ? (MXLEN-1)'(4)  : (MXLEN-1)'(6);

  assign w_tval = w_irq                             ? '0         :
                  (i_exc_iaddr_mis | i_exc_illegal) ? i_exc_tval :
                  i_exc_ebreak                      ? i_pc       :
                  i_exc_ecall                       ? '0         : i_exc_tval;

  assign w_base = {i_mtvec[MXLEN-1:2], 2'b00};
`ifdef TRAP_CTRL_VECTORED_EN
  assign w_vec = w_irq && (i_mtvec[1:0] == 2'b01);
`else
  assign w_vec = 1'b0;
`endif
  assign w_target = w_vec ? w_base + (MXLEN'(w_code) << 2) : w_base;
  assign w_unused = ^{w_en, i_mtvec[1:0]};

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state       <= IDLE;
      r_mip         <= '0;
      r_target      <= '0;
      o_trap_req    <= 1'b0;
      o_trap_cause  <= '0;
      o_trap_tval   <= '0;
      o_trap_pc     <= '0;
      o_mret_req    <= 1'b0;
      o_redirect    <= 1'b0;
      o_redirect_pc <= '0;
    end else begin
      r_mip      <= {i_irq_ext, i_irq_timer, i_irq_soft};
      o_trap_req <= 1'b0;
      o_mret_req <= 1'b0;
      o_redirect <= 1'b0;
      case (r_state)
        IDLE: if (w_sel) begin
          if (w_irq || w_exc) begin
            r_state      <= TRAP;
            o_trap_req   <= 1'b1;
            o_trap_cause <= {w_irq, w_code};
            o_trap_tval  <= w_tval;
            o_trap_pc    <= i_pc;
            r_target     <= w_target;
          end else begin
            r_state    <= MRET;
            o_mret_req <= 1'b1;
          end
        end
        TRAP: begin
          r_state       <= REDIR;
          o_redirect    <= 1'b1;
          o_redirect_pc <= r_target;
        end
        MRET: begin
          r_state       <= REDIR;
          o_redirect    <= 1'b1;
          o_redirect_pc <= i_mepc & ~MXLEN'(3);
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed and randomized checks of trap_ctrl against a priority-list reference model.
module tb_trap_ctrl;
  localparam int XL = 32;
  logic          i_clk = 1'b0, i_rst = 1'b1;
  logic          i_valid, i_exc_iaddr_mis, i_exc_illegal, i_exc_ebreak, i_exc_ecall;
  logic          i_exc_laddr_mis, i_exc_saddr_mis, i_mret, i_irq_soft, i_irq_timer, i_irq_ext;
  logic          i_mstatus_mie;
  logic [XL-1:0] i_pc, i_exc_tval, i_mie, i_mtvec, i_mepc;
  logic          o_flush, o_stall, o_trap_req, o_mret_req, o_redirect;
  logic [XL-1:0] o_trap_cause, o_trap_tval, o_trap_pc, o_redirect_pc, o_mip;
  int checks = 0, failures = 0;

  always #5 i_clk = ~i_clk;

  trap_ctrl #(.MXLEN(XL)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_pc(i_pc),
    .i_exc_iaddr_mis(i_exc_iaddr_mis), .i_exc_illegal(i_exc_illegal),
    .i_exc_ebreak(i_exc_ebreak), .i_exc_ecall(i_exc_ecall),
    .i_exc_laddr_mis(i_exc_laddr_mis), .i_exc_saddr_mis(i_exc_saddr_mis),
    .i_exc_tval(i_exc_tval), .i_mret(i_mret), .i_irq_soft(i_irq_soft),
    .i_irq_timer(i_irq_timer), .i_irq_ext(i_irq_ext), .i_mstatus_mie(i_mstatus_mie),
    .i_mie(i_mie), .i_mtvec(i_mtvec), .i_mepc(i_mepc),
    .o_flush(o_flush), .o_stall(o_stall), .o_trap_req(o_trap_req),
    .o_trap_cause(o_trap_cause), .o_trap_tval(o_trap_tval), .o_trap_pc(o_trap_pc),
    .o_mret_req(o_mret_req), .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
    .o_mip(o_mip)
  );

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_in;
    i_valid = 0; i_exc_iaddr_mis = 0; i_exc_illegal = 0; i_exc_ebreak = 0; i_exc_ecall = 0;
    i_exc_laddr_mis = 0; i_exc_saddr_mis = 0; i_mret = 0; i_irq_soft = 0; i_irq_timer = 0;
    i_irq_ext = 0; i_mstatus_mie = 0; i_pc = 0; i_exc_tval = 0; i_mie = 0; i_mtvec = 0; i_mepc = 0;
  endtask

  task automatic rand_in;
    i_valid = 1'($urandom); i_exc_iaddr_mis = 1'($urandom); i_exc_illegal = 1'($urandom);
    i_exc_ebreak = 1'($urandom); i_exc_ecall = 1'($urandom); i_exc_laddr_mis = 1'($urandom);
    i_exc_saddr_mis = 1'($urandom); i_mret = 1'($urandom); i_irq_soft = 1'($urandom);
    i_irq_timer = 1'($urandom); i_irq_ext = 1'($urandom); i_mstatus_mie = 1'($urandom);
    i_pc = $urandom; i_exc_tval = $urandom; i_mie = $urandom; i_mtvec = $urandom; i_mepc = $urandom;
  endtask

  // kind: 0 = nothing taken, 1 = trap, 2 = mret. Irq lines are assumed stable for a cycle.
  function automatic void model(output int kind, output logic [XL-1:0] cause, tval, tgt);
    logic [XL-1:0] pend, en, base;
    pend = (i_irq_ext ? 32'h800 : 0) | (i_irq_soft ? 32'h8 : 0) | (i_irq_timer ? 32'h80 : 0);
    en   = i_mstatus_mie ? (pend & i_mie) : 0;
    base = i_mtvec & 32'hFFFF_FFFC;
    kind = 1; cause = 0; tval = 0; tgt = base;
    if (en[11]) cause = 32'h8000_000B;
    else if (en[3]) cause = 32'h8000_0003;
    else if (en[7]) cause = 32'h8000_0007;
    else if (i_exc_iaddr_mis) begin cause = 0; tval = i_exc_tval; end
    else if (i_exc_illegal) begin cause = 2; tval = i_exc_tval; end
    else if (i_exc_ebreak) begin cause = 3; tval = i_pc; end
    else if (i_exc_ecall) cause = 11;
    else if (i_exc_laddr_mis) begin cause = 4; tval = i_exc_tval; end
    else if (i_exc_saddr_mis) begin cause = 6; tval = i_exc_tval; end
    else if (i_mret) begin kind = 2; tgt = i_mepc & 32'hFFFF_FFFC; end
    else kind = 0;
    if (!i_valid) kind = 0;
`ifdef TRAP_CTRL_VECTORED_EN
    if (cause[31] && i_mtvec[1:0] == 2'b01) tgt = base + 4 * (cause & 32'h7FFF_FFFF);
`endif
  endfunction

  task automatic run_event(input string name);
    int kind;
    logic [XL-1:0] ec, et, tg, pc;
    i_valid = 1;
    model(kind, ec, et, tg);
    pc = i_pc;
    #1;
    checks++;
    if (o_flush !== (kind != 0)) begin
      failures++; $display("FAIL %s flush got=%0b exp=%0b", name, o_flush, kind != 0);
    end
    tick;
    i_valid = 0;
    if (kind == 1) begin
      checks++;
      if ({o_trap_req, o_mret_req, o_stall} !== 3'b101 || o_trap_cause !== ec ||
          o_trap_tval !== et || o_trap_pc !== pc) begin
        failures++;
        $display("FAIL %s trap got req=%0b mret=%0b stall=%0b cause=%h tval=%h pc=%h exp cause=%h tval=%h pc=%h",
                 name, o_trap_req, o_mret_req, o_stall, o_trap_cause, o_trap_tval, o_trap_pc, ec, et, pc);
      end
    end else if (kind == 2) begin
      checks++;
      if ({o_trap_req, o_mret_req, o_stall} !== 3'b011) begin
        failures++;
        $display("FAIL %s mret got req=%0b mret=%0b stall=%0b exp 0/1/1", name, o_trap_req, o_mret_req, o_stall);
      end
    end else begin
      checks++;
      if ({o_trap_req, o_mret_req, o_stall} !== 3'b000) begin
        failures++;
        $display("FAIL %s idle got req=%0b mret=%0b stall=%0b exp 0/0/0", name, o_trap_req, o_mret_req, o_stall);
      end
    end
    if (kind != 0) begin
      tick;
      checks++;
      if (o_redirect !== 1'b1 || o_redirect_pc !== tg || o_trap_req !== 1'b0 || o_mret_req !== 1'b0) begin
        failures++;
        $display("FAIL %s redirect got v=%0b pc=%h req=%0b mret=%0b exp v=1 pc=%h", name,
                 o_redirect, o_redirect_pc, o_trap_req, o_mret_req, tg);
      end
      tick;
      checks++;
      if (o_redirect !== 1'b0 || o_stall !== 1'b0) begin
        failures++;
        $display("FAIL %s done got redirect=%0b stall=%0b exp 0/0", name, o_redirect, o_stall);
      end
    end
  endtask

  task automatic test_reset;
    #1 i_rst = 0;
    for (int i = 0; i < 5; i++) begin
      rand_in;
      tick;
      checks++;
      if ({o_flush, o_stall, o_trap_req, o_mret_req, o_redirect} !== 5'b0 || o_trap_cause !== 0 ||
          o_trap_tval !== 0 || o_trap_pc !== 0 || o_redirect_pc !== 0 || o_mip !== 0) begin
        failures++;
        $display("FAIL reset_hold got flush=%0b stall=%0b req=%0b mret=%0b redir=%0b cause=%h mip=%h exp all 0",
                 o_flush, o_stall, o_trap_req, o_mret_req, o_redirect, o_trap_cause, o_mip);
      end
    end
    clear_in;
    #1 i_rst = 1;
    run_event("reset_noflags");
  endtask

  task automatic test_illegal;
    clear_in;
    i_pc = 32'h100; i_exc_illegal = 1; i_exc_tval = 32'hFFFF_FFFF; i_mtvec = 32'h80;
    run_event("illegal");
    checks++;
    if (o_trap_cause !== 2 || o_redirect_pc !== 32'h80) begin
      failures++; $display("FAIL illegal_const cause=%h rpc=%h exp 2/80", o_trap_cause, o_redirect_pc);
    end
  endtask

  task automatic test_priority;
    clear_in;
    i_pc = 32'h200; i_exc_ecall = 1; i_exc_laddr_mis = 1; i_exc_tval = 32'h1234; i_mtvec = 32'h400;
    run_event("ecall_over_laddr");
    i_irq_ext = 1; i_irq_timer = 1; i_mie = 32'h880; i_mstatus_mie = 1;
    tick; tick;
    checks++;
    if (o_mip !== 32'h880) begin
      failures++; $display("FAIL mip got=%h exp=%h", o_mip, 32'h880);
    end
    run_event("irq_ext_over_ecall");
    checks++;
    if (o_trap_cause !== 32'h8000_000B) begin
      failures++; $display("FAIL irq_cause_const got=%h exp=8000000b", o_trap_cause);
    end
    i_mstatus_mie = 0;
    run_event("irq_masked_ecall");
  endtask

  task automatic test_mret;
    clear_in;
    i_mret = 1; i_mepc = 32'h203;
    run_event("mret");
    checks++;
    if (o_redirect_pc !== 32'h200) begin
      failures++; $display("FAIL mret_target got=%h exp=200", o_redirect_pc);
    end
  endtask

  task automatic test_mid_sequence;
    clear_in;
    i_pc = 32'h40; i_exc_illegal = 1; i_mtvec = 32'h300; i_valid = 1;
    tick;
    i_exc_illegal = 0; i_exc_ecall = 1; i_pc = 32'h44;
    #1;
    checks++;
    if (o_flush !== 1'b0 || o_trap_req !== 1'b1 || o_trap_cause !== 2) begin
      failures++; $display("FAIL mid_trap got flush=%0b req=%0b cause=%h exp 0/1/2", o_flush, o_trap_req, o_trap_cause);
    end
    tick;
    checks++;
    if (o_flush !== 1'b0 || o_redirect !== 1'b1 || o_redirect_pc !== 32'h300 || o_trap_cause !== 2) begin
      failures++;
      $display("FAIL mid_redir got flush=%0b redir=%0b pc=%h cause=%h exp 0/1/300/2", o_flush, o_redirect, o_redirect_pc, o_trap_cause);
    end
    i_valid = 0;
    tick;
    tick;
    checks++;
    if (o_trap_req !== 1'b0 || o_stall !== 1'b0) begin
      failures++; $display("FAIL mid_after got req=%0b stall=%0b exp 0/0", o_trap_req, o_stall);
    end
    clear_in;
    i_pc = 32'h80; i_exc_illegal = 1; i_mtvec = 32'h300; i_valid = 1;
    tick;
    i_valid = 0;
    i_rst = 0;
    #1;
    checks++;
    if (o_trap_req !== 1'b0 || o_stall !== 1'b0 || o_trap_cause !== 0) begin
      failures++; $display("FAIL rst_mid got req=%0b stall=%0b cause=%h exp 0/0/0", o_trap_req, o_stall, o_trap_cause);
    end
    #2 i_rst = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (o_redirect !== 1'b0 || o_trap_req !== 1'b0) begin
        failures++; $display("FAIL rst_mid_after%0d got redir=%0b req=%0b exp 0/0", i, o_redirect, o_trap_req);
      end
    end
  endtask

  task automatic test_vectored;
    logic [XL-1:0] exp_pc;
    clear_in;
    i_mtvec = 32'h101; i_irq_timer = 1; i_mie = 32'h80; i_mstatus_mie = 1; i_pc = 32'h500;
    tick;
    run_event("vec_timer");
`ifdef TRAP_CTRL_VECTORED_EN
    exp_pc = 32'h11C;
`else
    exp_pc = 32'h100;
`endif
    checks++;
    if (o_redirect_pc !== exp_pc) begin
      failures++; $display("FAIL vec_timer_const got=%h exp=%h", o_redirect_pc, exp_pc);
    end
    i_irq_timer = 0; i_exc_ecall = 1;
    tick;
    run_event("vec_ecall");
    checks++;
    if (o_redirect_pc !== 32'h100) begin
      failures++; $display("FAIL vec_ecall_const got=%h exp=100", o_redirect_pc);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 60; n++) begin
      clear_in;
      i_exc_iaddr_mis = $urandom_range(5) == 0; i_exc_illegal = $urandom_range(5) == 0;
      i_exc_ebreak = $urandom_range(5) == 0;    i_exc_ecall = $urandom_range(5) == 0;
      i_exc_laddr_mis = $urandom_range(5) == 0; i_exc_saddr_mis = $urandom_range(5) == 0;
      i_mret = $urandom_range(2) == 0;
      i_irq_soft = $urandom_range(3) == 0; i_irq_timer = $urandom_range(3) == 0;
      i_irq_ext = $urandom_range(3) == 0;  i_mstatus_mie = 1'($urandom);
      i_mie = $urandom; i_mtvec = $urandom; i_mepc = $urandom; i_pc = $urandom; i_exc_tval = $urandom;
      tick;
      run_event($sformatf("rand%0d", n));
    end
  endtask

  initial begin
    clear_in;
    test_reset;
    test_illegal;
    test_priority;
    test_mret;
    test_mid_sequence;
    test_vectored;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap initiator sitting between the commit stage and the CSR file.
- Collects synchronous exception flags, `mret`, and machine interrupt lines for the committing instruction. Picks the highest-priority event.
- Drives the CSR trap-entry handshake (request, cause, tval, saved PC), then redirects fetch to the trap vector or to `mepc`.
- Consumes `mtvec`/`mepc` back from the CSR file.

Parameters:
- MXLEN, 32, register/PC width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; asynchronous, active-low.
- i_valid  in  1  committing instruction valid this cycle.
- i_pc  in  MXLEN  PC of committing instruction.
- i_exc_iaddr_mis  in  1  instruction address misaligned.
- i_exc_illegal  in  1  illegal instruction.
- i_exc_ebreak  in  1  ebreak.
- i_exc_ecall  in  1  ecall (M-mode).
- i_exc_laddr_mis  in  1  load address misaligned.
- i_exc_saddr_mis  in  1  store address misaligned.
- i_exc_tval  in  MXLEN  faulting address, or instruction bits for illegal.
- i_mret  in  1  committing instruction is mret.
- i_irq_soft  in  1  machine software interrupt line, level.
- i_irq_timer  in  1  machine timer interrupt line, level.
- i_irq_ext  in  1  machine external interrupt line, level.
- i_mstatus_mie  in  1  global machine interrupt enable.
- i_mie  in  MXLEN  mie CSR.
- i_mtvec  in  MXLEN  mtvec CSR.
- i_mepc  in  MXLEN  mepc CSR.
- o_flush  out  1  combinational; kill the committing instruction (do not retire).
- o_stall  out  1  hold the pipeline; high when state != IDLE.
- o_trap_req  out  1  one-cycle trap-entry strobe to the CSR file.
- o_trap_cause  out  MXLEN  mcause value.
- o_trap_tval  out  MXLEN  mtval value.
- o_trap_pc  out  MXLEN  mepc value.
- o_mret_req  out  1  one-cycle mret strobe; CSR restores MIE from MPIE.
- o_redirect  out  1  one-cycle fetch redirect strobe.
- o_redirect_pc  out  MXLEN  redirect target.
- o_mip  out  MXLEN  pending bits: [3]=MSIP, [7]=MTIP, [11]=MEIP; all other bits 0.

Behaviour:
- Reset (i_rst=0, asynchronous):
  - state=IDLE.
  - All registered outputs and o_mip clear to 0.
  - Asserting reset mid-sequence aborts it; no trap_req or redirect is emitted afterwards.
- o_mip:
  - Each irq line is registered once, so the line is visible one cycle after it changes.
  - Pending-enabled set = o_mip & i_mie & {MXLEN{i_mstatus_mie}}.
- Event selection:
  - Active only in IDLE with i_valid=1. Ignored in every other state.
  - Priority, first match wins:
    1. Enabled interrupt, order MEI(11) > MSI(3) > MTI(7).
    2. iaddr_mis(0).
    3. illegal(2).
    4. ebreak(3).
    5. ecall(11).
    6. laddr_mis(4).
    7. saddr_mis(6).
    8. mret.
  - An exception or interrupt on an mret instruction wins over the mret.
- Cause and tval encoding:
  - Interrupt: cause = {1'b1, code}, tval = 0.
  - Misaligned: tval = i_exc_tval.
  - Illegal: tval = i_exc_tval.
  - ebreak: tval = i_pc.
  - ecall: tval = 0.
- o_flush:
  - Combinational; =1 in IDLE when an event is selected, including mret.
- FSM, states IDLE, TRAP, MRET, REDIR:
  - IDLE → TRAP on an interrupt or exception.
    - Register cause, tval, trap_pc = i_pc.
    - Register target = trap vector.
  - IDLE → MRET on mret.
  - TRAP: o_trap_req=1 for exactly one cycle → REDIR.
  - MRET: o_mret_req=1 for one cycle; capture target = i_mepc & ~3 → REDIR.
  - REDIR: o_redirect=1, o_redirect_pc=target for one cycle → IDLE.
- Timing and output holding:
  - Sequence latency is 3 cycles: flush cycle, then 2 stall cycles.
  - o_trap_cause, o_trap_tval, o_trap_pc hold their last values outside TRAP.
- Trap vector, base = {i_mtvec[MXLEN-1:2], 2'b00}, sampled in the IDLE cycle:
  - Default: target = base.
- Interrupt lines that deassert after selection do not cancel the sequence.

Optional Feature:
- Macro TRAP_CTRL_VECTORED_EN.
- Defined:
  - i_mtvec[1:0]=01 selects vectored mode.
  - Interrupts target base + 4*code, computed modulo 2^MXLEN.
  - Exceptions target base.
  - Modes 10/11 behave as direct.
- Undefined: mode bits are ignored; every trap targets base.

Test Plan:
- Reset:
  - Stimulus: hold i_rst=0, toggle all inputs.
  - Required: all outputs 0, o_stall=0.
  - Stimulus: release reset, i_valid=1 with no flags.
  - Required: no activity.
- Illegal instruction:
  - Stimulus: i_pc=0x100, i_exc_illegal=1, i_exc_tval=0xFFFFFFFF, i_mtvec=0x80.
  - Required: o_flush=1 same cycle.
  - Required: next cycle trap_req with cause=2, tval=0xFFFFFFFF, trap_pc=0x100.
  - Required: next cycle redirect to 0x80.
- Priority:
  - Stimulus: ecall and laddr_mis together.
  - Required: cause=11.
  - Stimulus: i_irq_ext and i_irq_timer high 2+ cycles, i_mie=0x880, i_mstatus_mie=1, plus ecall.
  - Required: cause=0x8000000B.
  - Stimulus: same with i_mstatus_mie=0.
  - Required: ecall taken.
- mret:
  - Stimulus: i_mret=1, i_mepc=0x203.
  - Required: o_mret_req one cycle, then redirect to 0x200, o_trap_req never asserted.
- Mid-sequence events and reset:
  - Stimulus: new exception presented during TRAP.
  - Required: ignored.
  - Stimulus: reset pulsed in TRAP.
  - Required: no o_redirect follows.
- Vectored (with TRAP_CTRL_VECTORED_EN), i_mtvec=0x101:
  - Stimulus: timer interrupt.
  - Required: redirect 0x11C.
  - Stimulus: ecall.
  - Required: redirect 0x100.
  - Stimulus: timer interrupt, macro undefined.
  - Required: redirect 0x100.
